mux_rr_arbiter16: RTL and testbench

- Round-robin arbiter that shares one 16-input datapath mux (and the resource behind it) among 16 requesters.
- Owns the 4-bit mux select, a one-hot grant vector and a grant-valid flag.
- Grants persist until the owner drops its request.
- Sits between the requesting units and the 16:1 select mux in the datapath.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_pick16.sv | 36 +++
 rtl/mux_rr_arbiter16.sv | 126 ++++++++++++
 tb/tb_mux_rr_arbiter16.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way round-robin mux arbiter.
// Holds requester count, select width, FSM state type and pointer reset value.
package arb_pkg;

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // first search after reset starts at requester 0
   localparam logic [SEL_W-1:0] PTR_RST = 4'hF;

   function automatic logic [N_REQ-1:0] onehot(
      input logic [SEL_W-1:0] i
   );
      return {{(N_REQ-1){1'b0}}, 1'b1} << i;
   endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin winner search: first set bit of req & ~mask after ptr.
// Ports: req, ptr, mask in; any (some bit eligible), idx (winner) out.
module rr_pick16
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic             any,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0]   eff;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [SEL_W-1:0]   start;
   logic [SEL_W-1:0]   off;

   assign eff   = req & ~mask;
   assign dbl   = {eff, eff};
   // wraps 15 -> 0; ptr itself lands in the last slot
   assign start = ptr + 1'b1;
   assign rot   = dbl[start +: N_REQ];

   // lowest set bit of the rotated vector wins
   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = SEL_W'(i);
      end
   end

   assign any = |eff;
   assign idx = start + off;

endmodule

// File: rtl/mux_rr_arbiter16.sv
// Round-robin owner of a shared 16:1 datapath mux; grants persist while held.
// Ports: clk, rst (sync, active-high), req[15:0] in;
//        gnt[15:0], gnt_vld, sel[3:0], tmo out (all registered).
// Macro ARB_HOLD_LIMIT_EN: revoke a grant after MAX_HOLD cycles, pulse tmo.
module mux_rr_arbiter16
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 255,
   parameter int CNT_W    = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] sel,
   output logic             tmo
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state;
   arb_state_t       state_nx;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_nx;
   logic [SEL_W-1:0] sel_nx;
   logic [SEL_W-1:0] win;
   logic [N_REQ-1:0] gnt_nx;
   logic [N_REQ-1:0] mask;
   logic             vld_nx;
   logic             any;
   logic             own_req;
   logic             expire;
   logic             grant_new;

   assign own_req = req[sel];

   // owner never re-wins on a handover; matters only on a forced revoke
   assign mask = (state == BUSY) ? onehot(sel) : '0;

   rr_pick16 u_pick (
      .req  (req),
      .ptr  (ptr),
      .mask (mask),
      .any  (any),
      .idx  (win)
   );

`ifdef ARB_HOLD_LIMIT_EN
   logic [CNT_W-1:0] cnt;

   assign expire = (state == BUSY) && own_req && (cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (grant_new) begin
         cnt <= '0;
      end else if (state == BUSY) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo <= 1'b0;
      end else begin
         tmo <= expire;
      end
   end
`else
   // hold limit compiled out: grants are unbounded
   assign expire = 1'b0 && (HOLD_LAST != '0);
   assign tmo    = 1'b0;
`endif

   always_comb begin
      state_nx  = state;
      gnt_nx    = gnt;
      vld_nx    = gnt_vld;
      sel_nx    = sel;
      ptr_nx    = ptr;
      grant_new = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) grant_new = 1'b1;
         end
         BUSY: begin
            if (!own_req || expire) begin
               if (any) begin
                  grant_new = 1'b1;
               end else begin
                  state_nx = IDLE;
                  gnt_nx   = '0;
                  vld_nx   = 1'b0;
               end
            end
         end
         default: ;
      endcase
      if (grant_new) begin
         state_nx = BUSY;
         gnt_nx   = onehot(win);
         vld_nx   = 1'b1;
         sel_nx   = win;
         ptr_nx   = win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         sel     <= '0;
         ptr     <= PTR_RST;
      end else begin
         state   <= state_nx;
         gnt     <= gnt_nx;
         gnt_vld <= vld_nx;
         sel     <= sel_nx;
         ptr     <= ptr_nx;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter16.sv
// Self-checking bench for mux_rr_arbiter16 (scoreboard of expected outputs).
// Builds with or without ARB_HOLD_LIMIT_EN; MAX_HOLD=4 when enabled.
`timescale 1ns/1ps
module tb_mux_rr_arbiter16;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HOLD = 4;
`else
   localparam int HOLD = 255;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] req = '0;
   logic [15:0] gnt;
   logic        gnt_vld;
   logic [3:0]  sel;
   logic        tmo;

   logic [21:0] obs;
   logic [21:0] e;
   logic [21:0] exp_q [$];
   int          n_chk  = 0;
   int          n_fail = 0;

   mux_rr_arbiter16 #(
      .MAX_HOLD (HOLD),
      .CNT_W    (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .sel     (sel),
      .tmo     (tmo)
   );

   always #5 clk = ~clk;

   assign obs = {gnt, gnt_vld, sel, tmo};

   function automatic logic [21:0] expv(
      input logic v, input logic [3:0] s, input logic t
   );
      logic [15:0] g;
      g = v ? (16'h0001 << s) : 16'h0000;
      return {g, v, s, t};
   endfunction

   task automatic step(input logic [15:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rst = 1'b1;
         exp_q.push_back(expv(1'b0, 4'd0, 1'b0));
         step(16'hFFFF);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [15:0] rq [4] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
      logic        ev [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(expv(ev[i], 4'd0, 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL single[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_rotation();
      logic [15:0] r;
      logic [3:0]  s;
      logic        v;
      for (int i = 0; i < 35; i++) begin
         rst = (i == 0);
         if (i == 0) begin
            r = 16'hFFFF; v = 1'b0; s = 4'd0;
         end else if (i == 1) begin
            r = 16'hFFFF; v = 1'b1; s = 4'd0;
         end else if (i == 34) begin
            r = 16'h0000; v = 1'b0; s = 4'd0;
         end else begin
            s = 4'((i / 2) % 16);
            v = 1'b1;
            r = (i % 2 == 0) ? ~(16'h0001 << ((i - 2) / 2)) : 16'hFFFF;
         end
         exp_q.push_back(expv(v, s, 1'b0));
         step(r);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rotation[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] rq [4] = '{16'h4000, 16'h4002, 16'h0002, 16'h0000};
      logic [3:0]  es [4] = '{4'd14, 4'd14, 4'd1, 4'd1};
      logic        ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(expv(ev[i], es[i], 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] rq [4] = '{16'h0004, 16'h0081, 16'h0080, 16'h0000};
      logic [3:0]  es [4] = '{4'd2, 4'd7, 4'd7, 4'd7};
      logic        ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(expv(ev[i], es[i], 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL simultaneous[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_ignore();
      logic [15:0] rq [5] = '{16'h0018, 16'h0008, 16'h0408, 16'h0400, 16'h0000};
      logic [3:0]  es [5] = '{4'd3, 4'd3, 4'd3, 4'd10, 4'd10};
      logic        ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(expv(ev[i], es[i], 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL ignore[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_rerequest();
      logic [15:0] rq [7] = '{16'h0020, 16'h0020, 16'h0020, 16'h0000,
                              16'h0000, 16'h0020, 16'h0000};
      logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(expv(ev[i], 4'd5, 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL rerequest[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rq [5] = '{16'h0200, 16'h0200, 16'h0200, 16'h0600, 16'h0000};
      logic        rs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0]  es [5] = '{4'd9, 4'd9, 4'd0, 4'd9, 4'd9};
      logic        ev [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         rst = rs[i];
         exp_q.push_back(expv(ev[i], es[i], 1'b0));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
      rst = 1'b0;
   endtask

`ifdef ARB_HOLD_LIMIT_EN
   task automatic test_hold_limit();
      logic [15:0] rq [16] = '{16'h0000, 16'h0011, 16'h0011, 16'h0011,
                               16'h0011, 16'h0011, 16'h0011, 16'h0011,
                               16'h0011, 16'h0011, 16'h0011, 16'h0001,
                               16'h0001, 16'h0001, 16'h0001, 16'h0000};
      logic [3:0]  es [16] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4,
                               4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      logic        ev [16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        et [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 16; i++) begin
         rst = (i == 0);
         exp_q.push_back(expv(ev[i], es[i], et[i]));
         step(rq[i]);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL hold_limit[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
      rst = 1'b0;
   endtask
`else
   task automatic test_unbounded();
      logic [15:0] r;
      for (int i = 0; i < 12; i++) begin
         r = (i < 11) ? 16'h0011 : 16'h0000;
         exp_q.push_back(expv(i < 11, 4'd0, 1'b0));
         step(r);
         e = exp_q.pop_front();
         n_chk++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL unbounded[%0d]: got gnt=%h vld=%b sel=%0d tmo=%b, required gnt=%h vld=%b sel=%0d tmo=%b",
                     i, gnt, gnt_vld, sel, tmo, e[21:6], e[5], e[4:1], e[0]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_simultaneous();
      test_ignore();
      test_rerequest();
      test_reset_mid();
`ifdef ARB_HOLD_LIMIT_EN
      test_hold_limit();
`else
      test_unbounded();
`endif
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
